// File: rtl/scheduler_gen2_pkg.sv
// Shared accelerator definitions for the scheduler stage.
// Holds the default datapath widths, FIFO sizing and the sentinel vertex id
// (all ones) that marks a vertex to be discarded instead of forwarded.
package scheduler_gen2_pkg;

  localparam int DEF_V_ID_WIDTH       = 32;
  localparam int DEF_V_VALUE_WIDTH    = 32;
  localparam int DEF_EDGE_WIDTH       = 32;
  localparam int DEF_ITERATION_WIDTH  = 8;
  localparam int DEF_FIFO_DEPTH       = 16;
  localparam int DEF_PROG_FULL_THRESH = 12;

  localparam int DROP_CNT_WIDTH = 16;

  // Sentinel id; the top slices the low V_ID_WIDTH bits (ids up to 64 bits).
  localparam logic [63:0] SENTINEL_ID_MAX = '1;

endpackage

// File: rtl/sync_fifo_fwft.sv
// Synchronous first-word-fall-through FIFO.
// Ports:
//   clk, rst   - clock, synchronous active-high reset (clears pointers/count)
//   push, din  - write request and data; accepted while not full, or when
//                full but a pop happens in the same cycle
//   pop        - consume the head; ignored while empty
//   dout       - current head (valid whenever count != 0)
//   count      - occupancy, one bit wider than the pointers
//   overflow   - one-cycle pulse when a push is rejected (data discarded)
module sync_fifo_fwft #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             pop_ok;
  logic             push_ok;

  assign pop_ok  = !rst && pop && (count_reg != '0);
  // At full, a same-cycle pop frees the slot the write lands in.
  assign push_ok = !rst && push && ((count_reg != FULL_COUNT) || pop_ok);
  assign overflow = !rst && push && !push_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_reg + CW'(push_ok) - CW'(pop_ok);
    end
  end

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg] <= din;
  end

  // Asynchronous head read gives first-word-fall-through behaviour.
  assign dout  = mem[rd_ptr_reg];
  assign count = count_reg;

endmodule

// File: rtl/scheduler_gen2.sv
// Scheduler stage: pairs active vertices with edge addresses.
// Ports:
//   front_active_v_*      - vertex {id,value} push into the vertex FIFO
//   edge_addr*            - edge address push into the edge FIFO
//   front_iteration_*     - iteration-end request and its id
//   next_stage_full       - downstream backpressure, stalls pairing
//   update_v_*            - registered paired update (edge head, value head)
//   iteration_end*/iteration_id - registered iteration-end report
//   stage_full            - vertex occupancy at/above PROG_FULL_THRESH
//   v_count / e_count     - FIFO occupancies
//   overflow              - sticky flag, set by any rejected push
//   sentinel_drops        - saturating count of sentinel vertices discarded
module scheduler_gen2
  import scheduler_gen2_pkg::*;
#(
  parameter int V_ID_WIDTH       = DEF_V_ID_WIDTH,
  parameter int V_VALUE_WIDTH    = DEF_V_VALUE_WIDTH,
  parameter int EDGE_WIDTH       = DEF_EDGE_WIDTH,
  parameter int ITERATION_WIDTH  = DEF_ITERATION_WIDTH,
  parameter int FIFO_DEPTH       = DEF_FIFO_DEPTH,
  parameter int PROG_FULL_THRESH = DEF_PROG_FULL_THRESH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [V_ID_WIDTH-1:0]         front_active_v_id,
  input  logic [V_VALUE_WIDTH-1:0]      front_active_v_value,
  input  logic                          front_active_v_valid,
  input  logic                          front_iteration_end,
  input  logic                          front_iteration_end_valid,
  input  logic [ITERATION_WIDTH-1:0]    front_iteration_id,
  input  logic [EDGE_WIDTH-1:0]         edge_addr,
  input  logic                          edge_addr_valid,
  input  logic                          next_stage_full,
  output logic [EDGE_WIDTH-1:0]         update_v_id,
  output logic [V_VALUE_WIDTH-1:0]      update_v_value,
  output logic                          update_v_valid,
  output logic                          iteration_end,
  output logic                          iteration_end_valid,
  output logic [ITERATION_WIDTH-1:0]    iteration_id,
  output logic                          stage_full,
  output logic [$clog2(FIFO_DEPTH):0]   v_count,
  output logic [$clog2(FIFO_DEPTH):0]   e_count,
  output logic                          overflow,
  output logic [DROP_CNT_WIDTH-1:0]     sentinel_drops
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int VW = V_ID_WIDTH + V_VALUE_WIDTH;
  localparam logic [V_ID_WIDTH-1:0] SENTINEL_ID = SENTINEL_ID_MAX[V_ID_WIDTH-1:0];

  logic [VW-1:0]            v_head;
  logic [V_ID_WIDTH-1:0]    v_head_id;
  logic [V_VALUE_WIDTH-1:0] v_head_value;
  logic [EDGE_WIDTH-1:0]    e_head;
  logic                     v_ovf;
  logic                     e_ovf;
  logic                     v_empty;
  logic                     e_empty;
  logic                     pop;
  logic                     is_sentinel;
  logic                     iter_fire;

  logic [EDGE_WIDTH-1:0]     update_v_id_reg;
  logic [V_VALUE_WIDTH-1:0]  update_v_value_reg;
  logic                      update_v_valid_reg;
  logic                      iteration_end_reg;
  logic [ITERATION_WIDTH-1:0] iteration_id_reg;
  logic                      overflow_reg;
  logic [DROP_CNT_WIDTH-1:0] sentinel_drops_reg;

  sync_fifo_fwft #(.WIDTH(VW), .DEPTH(FIFO_DEPTH)) u_vertex_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (front_active_v_valid),
    .din      ({front_active_v_id, front_active_v_value}),
    .pop      (pop),
    .dout     (v_head),
    .count    (v_count),
    .overflow (v_ovf)
  );

  sync_fifo_fwft #(.WIDTH(EDGE_WIDTH), .DEPTH(FIFO_DEPTH)) u_edge_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (edge_addr_valid),
    .din      (edge_addr),
    .pop      (pop),
    .dout     (e_head),
    .count    (e_count),
    .overflow (e_ovf)
  );

  assign v_head_id    = v_head[VW-1:V_VALUE_WIDTH];
  assign v_head_value = v_head[V_VALUE_WIDTH-1:0];
  assign v_empty      = (v_count == '0);
  assign e_empty      = (e_count == '0);

  // Both heads leave together so vertices and edges never drift apart.
  assign pop         = !rst && !next_stage_full && !v_empty && !e_empty;
  assign is_sentinel = (v_head_id == SENTINEL_ID);

  // Iteration ends only when nothing is queued and nothing is arriving.
  assign iter_fire = front_iteration_end && front_iteration_end_valid &&
                     v_empty && e_empty &&
                     !front_active_v_valid && !edge_addr_valid;

  assign stage_full = (v_count >= CW'(PROG_FULL_THRESH));

  always_ff @(posedge clk) begin
    if (rst) begin
      update_v_id_reg    <= '0;
      update_v_value_reg <= '0;
      update_v_valid_reg <= 1'b0;
      iteration_end_reg  <= 1'b0;
      iteration_id_reg   <= '0;
      overflow_reg       <= 1'b0;
      sentinel_drops_reg <= '0;
    end else begin
      if (pop && !is_sentinel) begin
        update_v_id_reg    <= e_head;
        update_v_value_reg <= v_head_value;
        update_v_valid_reg <= 1'b1;
      end else begin
        update_v_id_reg    <= '0;
        update_v_value_reg <= '0;
        update_v_valid_reg <= 1'b0;
      end
      if (pop && is_sentinel && (sentinel_drops_reg != '1))
        sentinel_drops_reg <= sentinel_drops_reg + DROP_CNT_WIDTH'(1);
      overflow_reg      <= overflow_reg | v_ovf | e_ovf;
      iteration_end_reg <= iter_fire;
      iteration_id_reg  <= front_iteration_id;
    end
  end

  assign update_v_id         = update_v_id_reg;
  assign update_v_value      = update_v_value_reg;
  assign update_v_valid      = update_v_valid_reg;
  assign iteration_end       = iteration_end_reg;
  assign iteration_end_valid = iteration_end_reg;
  assign iteration_id        = iteration_id_reg;
  assign overflow            = overflow_reg;
  assign sentinel_drops      = sentinel_drops_reg;

endmodule

// File: tb/tb_scheduler_gen2.sv
// Directed self-checking bench for scheduler_gen2 (default parameters).
// Inputs change 1 ns after a rising edge; outputs are checked at that point.
module tb_scheduler_gen2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] front_active_v_id;
  logic [31:0] front_active_v_value;
  logic        front_active_v_valid;
  logic        front_iteration_end;
  logic        front_iteration_end_valid;
  logic [7:0]  front_iteration_id;
  logic [31:0] edge_addr;
  logic        edge_addr_valid;
  logic        next_stage_full;
  logic [31:0] update_v_id;
  logic [31:0] update_v_value;
  logic        update_v_valid;
  logic        iteration_end;
  logic        iteration_end_valid;
  logic [7:0]  iteration_id;
  logic        stage_full;
  logic [4:0]  v_count;
  logic [4:0]  e_count;
  logic        overflow;
  logic [15:0] sentinel_drops;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  scheduler_gen2 dut (
    .clk                       (clk),
    .rst                       (rst),
    .front_active_v_id         (front_active_v_id),
    .front_active_v_value      (front_active_v_value),
    .front_active_v_valid      (front_active_v_valid),
    .front_iteration_end       (front_iteration_end),
    .front_iteration_end_valid (front_iteration_end_valid),
    .front_iteration_id        (front_iteration_id),
    .edge_addr                 (edge_addr),
    .edge_addr_valid           (edge_addr_valid),
    .next_stage_full           (next_stage_full),
    .update_v_id               (update_v_id),
    .update_v_value            (update_v_value),
    .update_v_valid            (update_v_valid),
    .iteration_end             (iteration_end),
    .iteration_end_valid       (iteration_end_valid),
    .iteration_id              (iteration_id),
    .stage_full                (stage_full),
    .v_count                   (v_count),
    .e_count                   (e_count),
    .overflow                  (overflow),
    .sentinel_drops            (sentinel_drops)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
    $display("check %-24s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic push_v(input logic [31:0] id, input logic [31:0] val);
    front_active_v_id    = id;
    front_active_v_value = val;
    front_active_v_valid = 1'b1;
  endtask

  task automatic push_e(input logic [31:0] a);
    edge_addr       = a;
    edge_addr_valid = 1'b1;
  endtask

  task automatic idle_push();
    front_active_v_valid = 1'b0;
    edge_addr_valid      = 1'b0;
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_v_count"}, 64'(v_count), 64'd0);
    chk({tag, "_e_count"}, 64'(e_count), 64'd0);
    chk({tag, "_valid"}, 64'(update_v_valid), 64'd0);
    chk({tag, "_upd_id"}, 64'(update_v_id), 64'd0);
    chk({tag, "_iter_end"}, 64'(iteration_end), 64'd0);
    chk({tag, "_overflow"}, 64'(overflow), 64'd0);
    chk({tag, "_drops"}, 64'(sentinel_drops), 64'd0);
    chk({tag, "_stage_full"}, 64'(stage_full), 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    front_active_v_id = '0; front_active_v_value = '0; front_active_v_valid = 1'b0;
    front_iteration_end = 1'b0; front_iteration_end_valid = 1'b0; front_iteration_id = '0;
    edge_addr = '0; edge_addr_valid = 1'b0; next_stage_full = 1'b0;
    tick(); tick();
    chk_cleared("reset");
    chk("reset_iter_id", 64'(iteration_id), 64'd0);
    rst = 1'b0;

    // Single pair: update appears the cycle after the pop.
    push_v(32'd5, 32'd7); push_e(32'h100);
    tick(); idle_push();
    chk("pair_v_count", 64'(v_count), 64'd1);
    chk("pair_e_count", 64'(e_count), 64'd1);
    tick();
    chk("pair_upd_id", 64'(update_v_id), 64'h100);
    chk("pair_upd_value", 64'(update_v_value), 64'd7);
    chk("pair_upd_valid", 64'(update_v_valid), 64'd1);
    chk("pair_v_drained", 64'(v_count), 64'd0);
    tick();
    chk("pair_idle_valid", 64'(update_v_valid), 64'd0);
    chk("pair_idle_id", 64'(update_v_id), 64'd0);

    // Sentinel vertex is consumed with its edge but never forwarded.
    push_v(32'hFFFF_FFFF, 32'd9); push_e(32'h200);
    tick(); idle_push();
    tick();
    chk("sent_valid", 64'(update_v_valid), 64'd0);
    chk("sent_upd_id", 64'(update_v_id), 64'd0);
    chk("sent_drops", 64'(sentinel_drops), 64'd1);
    chk("sent_v_count", 64'(v_count), 64'd0);
    chk("sent_e_count", 64'(e_count), 64'd0);

    // Fill vertex FIFO with no edges: threshold, full, then overflow.
    for (int i = 0; i < 11; i++) begin
      push_v(32'(i + 10), 32'(i * 3)); tick();
    end
    chk("fill11_count", 64'(v_count), 64'd11);
    chk("fill11_stage_full", 64'(stage_full), 64'd0);
    push_v(32'd21, 32'd33); tick();
    chk("fill12_count", 64'(v_count), 64'd12);
    chk("fill12_stage_full", 64'(stage_full), 64'd1);
    for (int i = 0; i < 4; i++) begin
      push_v(32'(i + 22), 32'd1); tick();
    end
    chk("fill16_count", 64'(v_count), 64'd16);
    chk("fill16_overflow", 64'(overflow), 64'd0);
    push_v(32'd99, 32'd99); tick(); idle_push();
    chk("push17_count", 64'(v_count), 64'd16);
    chk("push17_overflow", 64'(overflow), 64'd1);
    chk("push17_e_count", 64'(e_count), 64'd0);
    tick();
    chk("overflow_sticky", 64'(overflow), 64'd1);

    // Reset clears FIFOs, sticky flag and drop counter.
    rst = 1'b1; tick(); rst = 1'b0;
    chk_cleared("rst_full");

    // Backpressure holds three pairs, release drains them in order.
    next_stage_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push_v(32'(i + 1), 32'(8'h11 * (i + 1))); push_e(32'(8'hA0 + i)); tick();
    end
    idle_push();
    chk("bp_v_count", 64'(v_count), 64'd3);
    chk("bp_e_count", 64'(e_count), 64'd3);
    chk("bp_valid", 64'(update_v_valid), 64'd0);
    tick();
    chk("bp_hold_valid", 64'(update_v_valid), 64'd0);
    next_stage_full = 1'b0;
    tick();
    chk("bp_u0_id", 64'(update_v_id), 64'hA0);
    chk("bp_u0_val", 64'(update_v_value), 64'h11);
    chk("bp_u0_valid", 64'(update_v_valid), 64'd1);
    tick();
    chk("bp_u1_id", 64'(update_v_id), 64'hA1);
    chk("bp_u1_val", 64'(update_v_value), 64'h22);
    chk("bp_u1_valid", 64'(update_v_valid), 64'd1);
    tick();
    chk("bp_u2_id", 64'(update_v_id), 64'hA2);
    chk("bp_u2_val", 64'(update_v_value), 64'h33);
    chk("bp_u2_valid", 64'(update_v_valid), 64'd1);
    tick();
    chk("bp_done_valid", 64'(update_v_valid), 64'd0);
    chk("bp_done_count", 64'(v_count), 64'd0);

    // Iteration end refused while a vertex is queued.
    push_v(32'd4, 32'd4); tick(); idle_push();
    front_iteration_end = 1'b1; front_iteration_end_valid = 1'b1; front_iteration_id = 8'h5A;
    tick();
    front_iteration_end = 1'b0; front_iteration_end_valid = 1'b0;
    chk("ie_busy_end", 64'(iteration_end), 64'd0);
    chk("ie_busy_id", 64'(iteration_id), 64'h5A);
    push_e(32'h300); tick(); idle_push();
    tick();
    chk("ie_drain_id", 64'(update_v_id), 64'h300);
    chk("ie_drain_val", 64'(update_v_value), 64'd4);
    front_iteration_end = 1'b1; front_iteration_end_valid = 1'b1; front_iteration_id = 8'h3C;
    tick();
    front_iteration_end = 1'b0; front_iteration_end_valid = 1'b0; front_iteration_id = 8'h01;
    chk("ie_end", 64'(iteration_end), 64'd1);
    chk("ie_end_valid", 64'(iteration_end_valid), 64'd1);
    chk("ie_id", 64'(iteration_id), 64'h3C);
    tick();
    chk("ie_one_cycle", 64'(iteration_end), 64'd0);
    chk("ie_id_follow", 64'(iteration_id), 64'h01);

    // Request with a push arriving that cycle is refused; then queue 5 and reset.
    front_iteration_end = 1'b1; front_iteration_end_valid = 1'b1;
    push_v(32'd50, 32'd50); tick();
    front_iteration_end = 1'b0; front_iteration_end_valid = 1'b0;
    chk("ie_push_end", 64'(iteration_end), 64'd0);
    for (int i = 0; i < 4; i++) begin
      push_v(32'(i + 51), 32'd0); tick();
    end
    idle_push();
    chk("mid_v_count", 64'(v_count), 64'd5);
    rst = 1'b1; push_v(32'd70, 32'd70); push_e(32'h700); tick();
    rst = 1'b0; idle_push();
    chk_cleared("rst_mid");
    push_v(32'd8, 32'h88); push_e(32'h400); tick(); idle_push();
    tick();
    chk("post_rst_id", 64'(update_v_id), 64'h400);
    chk("post_rst_val", 64'(update_v_value), 64'h88);
    chk("post_rst_valid", 64'(update_v_valid), 64'd1);

    // Both FIFOs full: simultaneous push and pop keeps counts at 16.
    next_stage_full = 1'b1;
    for (int i = 0; i < 16; i++) begin
      push_v(32'(i), 32'(i + 8'h40)); push_e(32'(i + 12'h500)); tick();
    end
    chk("full_v_count", 64'(v_count), 64'd16);
    chk("full_e_count", 64'(e_count), 64'd16);
    next_stage_full = 1'b0;
    push_v(32'h77, 32'h77); push_e(32'h777); tick(); idle_push();
    chk("fullpp_v_count", 64'(v_count), 64'd15 + 64'd1);
    chk("fullpp_e_count", 64'(e_count), 64'd16);
    chk("fullpp_overflow", 64'(overflow), 64'd0);
    chk("fullpp_upd_id", 64'(update_v_id), 64'h500);
    chk("fullpp_upd_val", 64'(update_v_value), 64'h40);
    next_stage_full = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/scheduler_gen2.md
SCHEDULER_GEN2 -- requirements
Module: scheduler_gen2

Interface
REQ-001 SHALL have parameter V_ID_WIDTH, default 32, vertex id width.
REQ-002 SHALL have parameter V_VALUE_WIDTH, default 32, vertex value width.
REQ-003 SHALL have parameter EDGE_WIDTH, default 32, edge address width.
REQ-004 SHALL have parameter ITERATION_WIDTH, default 8, iteration id width.
REQ-005 SHALL have parameter FIFO_DEPTH, default 16, entries per FIFO; power of two, >= 4.
REQ-006 SHALL have parameter PROG_FULL_THRESH, default 12, occupancy at which stage_full asserts; < FIFO_DEPTH.
REQ-007 SHALL have port clk, input, 1, clock.
REQ-008 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-009 SHALL have ports front_active_v_id / front_active_v_value / front_active_v_valid, input, V_ID_WIDTH / V_VALUE_WIDTH / 1, active vertex push.
REQ-010 SHALL have ports front_iteration_end / front_iteration_end_valid / front_iteration_id, input, 1 / 1 / ITERATION_WIDTH, iteration-end request.
REQ-011 SHALL have ports edge_addr / edge_addr_valid, input, EDGE_WIDTH / 1, edge address push from HBM interface.
REQ-012 SHALL have port next_stage_full, input, 1, downstream backpressure.
REQ-013 SHALL have ports update_v_id / update_v_value / update_v_valid, output, EDGE_WIDTH / V_VALUE_WIDTH / 1, paired update.
REQ-014 SHALL have ports iteration_end / iteration_end_valid / iteration_id, output, 1 / 1 / ITERATION_WIDTH.
REQ-015 SHALL have port stage_full, output, 1, vertex FIFO occupancy >= PROG_FULL_THRESH.
REQ-016 SHALL have ports v_count / e_count, output, $clog2(FIFO_DEPTH)+1 each, current FIFO occupancies.
REQ-017 SHALL have ports overflow / sentinel_drops, output, 1 / 16, sticky overflow flag and sentinel drop counter.

Function
REQ-018 SHALL store {id,value} in a first-word-fall-through vertex FIFO and edge_addr in a separate FWFT edge FIFO.
REQ-019 SHALL pop both FIFOs in the same cycle iff !next_stage_full and both non-empty; never pop one alone.
REQ-020 SHALL accept a push iff count < FIFO_DEPTH or a pop occurs that cycle; a rejected push SHALL set overflow and discard data.
REQ-021 SHALL, on pop with id != all-ones, register update_v_id=edge head, update_v_value=value head, update_v_valid=1 next cycle (latency 1).
REQ-022 SHALL, on pop with id == all-ones (sentinel), consume both heads, drive update_v_valid=0, increment sentinel_drops (saturating at 16'hFFFF).
REQ-023 SHALL drive update_v_id/value/valid to 0 in any cycle following no pop.
REQ-024 SHALL assert iteration_end and iteration_end_valid for one cycle, one cycle after a request cycle in which both FIFOs are empty and neither push valid is high; otherwise drive both 0.
REQ-025 SHALL register iteration_id <= front_iteration_id every cycle regardless of request.
REQ-026 SHALL derive stage_full combinationally from current vertex FIFO count.
REQ-027 SHALL wrap FIFO pointers modulo FIFO_DEPTH using an extra occupancy bit; simultaneous push+pop at full or empty SHALL leave count unchanged.

Reset
REQ-028 SHALL on rst clear both FIFOs, counts, overflow, sentinel_drops and drive all outputs 0 the following cycle.
REQ-029 SHALL ignore pushes, pops and iteration-end requests in any cycle rst is high, including mid-stream.

Structure
REQ-030 SHALL take width defaults from the shared accelerator header/package; sentinel constant (all-ones id) SHALL live there.
REQ-031 SHALL instantiate sub-module sync_fifo_fwft (parametrised width, depth) twice; no vendor FIFO IP.

Verification
REQ-032 Push id=5,val=7 and edge=0x100, next_stage_full=0 -> cycle+1 update_v_id=0x100, value=7, valid=1.
REQ-033 Push id=0xFFFFFFFF with edge=0x200 -> no valid update, sentinel_drops 0->1, both counts back to 0.
REQ-034 Push 12 vertices, no edges -> stage_full=1 at count 12; 17th push with 16 stored -> overflow=1, v_count stays 16.
REQ-035 Hold next_stage_full=1 with 3 pairs queued, release -> 3 consecutive valid updates in order, no loss.
REQ-036 Iteration-end request with 1 vertex queued -> no iteration_end; repeat after drain -> iteration_end=1 for exactly one cycle with iteration_id=request id.
REQ-037 Assert rst with 5 entries queued -> cycle+1 counts 0, all outputs 0, subsequent push/pop normal.
